// File: rtl/alu_sin_decoder.sv
// Serial request decoder: frames from sin are assembled into {B,A,op} packets,
// checked (count, CRC-4, opcode) and handed to the ALU core through a valid/ready hold.
module alu_sin_decoder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sin,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [31:0] a,
  output logic [31:0] b,
  output logic [2:0]  op,
  output logic        err_data,
  output logic        err_crc,
  output logic        err_op,
  output logic        frame_err,
  output logic        overflow
);

  typedef enum logic [1:0] {S_IDLE, S_TYPE, S_PAYLOAD, S_STOP} state_t;

  state_t      r_state;
  logic [2:0]  r_bitcnt;
  logic        r_type;
  logic [7:0]  r_pay;
  logic [63:0] r_data;
  logic [3:0]  r_dcnt;
  logic        r_cmd_done;
  logic [2:0]  r_cmd_op;
  logic [3:0]  r_cmd_crc;

  logic [3:0]  w_crc_exp;
  logic        w_load;

  // CRC-4, x^4+x+1, init 0, message shifted MSB first
  function automatic logic [3:0] crc4(input logic [67:0] msg);
    logic [3:0] c;
    logic       fb;
    c = '0;
    for (int unsigned i = 0; i < 68; i++) begin
      fb = c[3] ^ msg[67 - i];
      c  = {c[2:0], 1'b0} ^ {2'b00, fb, fb};
    end
    return c;
  endfunction

  assign w_crc_exp = crc4({r_data, 1'b1, r_cmd_op});
  assign w_load    = r_cmd_done && (!out_valid || out_ready);

  // Frame FSM and packet assembly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_bitcnt   <= '0;
      r_type     <= 1'b0;
      r_pay      <= '0;
      r_data     <= '0;
      r_dcnt     <= '0;
      r_cmd_done <= 1'b0;
      r_cmd_op   <= '0;
      r_cmd_crc  <= '0;
      frame_err  <= 1'b0;
    end else begin
      frame_err  <= 1'b0;
      r_cmd_done <= 1'b0;
      // The packet is evaluated one cycle after the CMD stop bit, so the
      // assembly registers are cleared then rather than at the stop edge.
      if (r_cmd_done) begin
        r_data <= '0;
        r_dcnt <= '0;
      end
      case (r_state)
        S_IDLE: begin
          if (!sin) r_state <= S_TYPE;
        end
        S_TYPE: begin
          r_type   <= sin;
          r_bitcnt <= '0;
          r_state  <= S_PAYLOAD;
        end
        S_PAYLOAD: begin
          r_pay    <= {r_pay[6:0], sin};
          r_bitcnt <= r_bitcnt + 3'd1;
          if (r_bitcnt == 3'd7) r_state <= S_STOP;
        end
        S_STOP: begin
          r_state <= S_IDLE;
          if (!sin) begin
            frame_err <= 1'b1;
            r_data    <= '0;
            r_dcnt    <= '0;
          end else if (r_type) begin
            r_cmd_done <= 1'b1;
            r_cmd_op   <= r_pay[6:4];
            r_cmd_crc  <= r_pay[3:0];
          end else begin
            // Bytes land left-aligned so unreceived trailing bytes stay zero
            for (int unsigned i = 0; i < 8; i++) begin
              if (r_dcnt == 4'(i)) r_data[(7 - i) * 8 +: 8] <= r_pay;
            end
            if (r_dcnt != 4'd9) r_dcnt <= r_dcnt + 4'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Result hold towards the ALU core
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      a         <= '0;
      b         <= '0;
      op        <= '0;
      err_data  <= 1'b0;
      err_crc   <= 1'b0;
      err_op    <= 1'b0;
      overflow  <= 1'b0;
    end else if (w_load) begin
      out_valid <= 1'b1;
      a         <= r_data[31:0];
      b         <= r_data[63:32];
      op        <= r_cmd_op;
      err_data  <= (r_dcnt != 4'd8);
      err_crc   <= (r_dcnt == 4'd8) && (w_crc_exp != r_cmd_crc);
      err_op    <= (r_dcnt == 4'd8) && (w_crc_exp == r_cmd_crc) && r_cmd_op[1];
    end else begin
      if (r_cmd_done) overflow <= 1'b1;
      if (out_valid && out_ready) out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_sin_decoder.sv
// Directed bench for alu_sin_decoder: drives serial packets and checks the
// decoded result, error flags, handshake timing, frame errors and reset.
module tb_alu_sin_decoder;

  logic        clk;
  logic        rst_n;
  logic        sin;
  logic        out_ready;
  logic        out_valid;
  logic [31:0] a;
  logic [31:0] b;
  logic [2:0]  op;
  logic        err_data;
  logic        err_crc;
  logic        err_op;
  logic        frame_err;
  logic        overflow;

  int n_checks = 0;
  int n_pass   = 0;

  alu_sin_decoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sin       (sin),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .a         (a),
    .b         (b),
    .op        (op),
    .err_data  (err_data),
    .err_crc   (err_crc),
    .err_op    (err_op),
    .frame_err (frame_err),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference CRC by polynomial long division of the augmented message
  function automatic logic [3:0] ref_crc(input logic [31:0] bv, input logic [31:0] av,
                                         input logic [2:0] opv);
    logic [71:0] r;
    r = {bv, av, 1'b1, opv, 4'b0000};
    for (int i = 71; i >= 4; i--) begin
      if (r[i]) r[i -: 5] = r[i -: 5] ^ 5'b10011;
    end
    return r[3:0];
  endfunction

  task automatic send_frame(input logic typ, input logic [7:0] pay, input logic stop);
    @(negedge clk) sin = 1'b0;
    @(negedge clk) sin = typ;
    for (int i = 7; i >= 0; i--) begin
      @(negedge clk) sin = pay[i];
    end
    @(negedge clk) sin = stop;
  endtask

  task automatic send_packet(input logic [31:0] bv, input logic [31:0] av, input logic [2:0] opv,
                             input logic [3:0] crc_delta, input int ndata);
    logic [63:0] d;
    logic [3:0]  c;
    d = {bv, av};
    for (int i = 0; i < ndata; i++) send_frame(1'b0, d[63 - 8 * i -: 8], 1'b1);
    c = ref_crc(bv, av, opv) + crc_delta;
    send_frame(1'b1, {1'b0, opv, c}, 1'b1);
  endtask

  task automatic accept();
    @(negedge clk) out_ready = 1'b1;
    @(negedge clk) out_ready = 1'b0;
    check("accept_drop", {63'd0, out_valid}, 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; sin = 1'b1; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", {63'd0, out_valid}, 64'd0);
    check("rst_ab",    {b, a}, 64'd0);
    check("rst_flags", {58'd0, op, err_data, err_crc, err_op, frame_err, overflow}, 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Valid add, 1-cycle latency after CMD stop
    send_packet(32'h0000_0002, 32'h0000_0003, 3'b100, 4'd0, 8);
    @(negedge clk);
    check("add_latency", {63'd0, out_valid}, 64'd0);
    @(negedge clk);
    check("add_valid", {63'd0, out_valid}, 64'd1);
    check("add_ab",    {b, a}, 64'h0000_0002_0000_0003);
    check("add_op",    {61'd0, op}, 64'd4);
    check("add_errs",  {61'd0, err_data, err_crc, err_op}, 64'd0);

    // Bad CRC completing on the same edge as the acceptance of the add
    send_packet(32'h1234_5678, 32'h9ABC_DEF0, 3'b000, 4'd1, 8);
    @(negedge clk) out_ready = 1'b1;
    check("hold_a", {32'd0, a}, 64'd3);
    @(negedge clk) out_ready = 1'b0;
    check("crc_valid", {63'd0, out_valid}, 64'd1);
    check("crc_ab",    {b, a}, 64'h1234_5678_9ABC_DEF0);
    check("crc_errs",  {61'd0, err_data, err_crc, err_op}, 64'b010);
    check("crc_ovf",   {63'd0, overflow}, 64'd0);
    accept();

    // Short packet: 7 DATA frames
    send_packet(32'hAABB_CCDD, 32'h1122_3344, 3'b100, 4'd0, 7);
    repeat (2) @(negedge clk);
    check("short_errs", {61'd0, err_data, err_crc, err_op}, 64'b100);
    check("short_ab",   {b, a}, 64'hAABB_CCDD_1122_3300);
    accept();

    // Illegal opcode with a correct CRC
    send_packet(32'h0000_0005, 32'h0000_0007, 3'b010, 4'd0, 8);
    repeat (2) @(negedge clk);
    check("op_errs", {61'd0, err_data, err_crc, err_op}, 64'b001);
    check("op_val",  {61'd0, op}, 64'd2);
    accept();

    // Stop bit low on DATA frame 3
    send_frame(1'b0, 8'h55, 1'b1);
    send_frame(1'b0, 8'h66, 1'b1);
    send_frame(1'b0, 8'h77, 1'b0);
    @(negedge clk);
    check("ferr_pulse", {63'd0, frame_err}, 64'd1);
    sin = 1'b1;
    @(negedge clk);
    check("ferr_single", {63'd0, frame_err}, 64'd0);
    send_packet(32'hDEAD_BEEF, 32'h0102_0304, 3'b001, 4'd0, 8);
    repeat (2) @(negedge clk);
    check("p1_valid", {63'd0, out_valid}, 64'd1);
    check("p1_ab",    {b, a}, 64'hDEAD_BEEF_0102_0304);
    check("p1_errs",  {61'd0, err_data, err_crc, err_op}, 64'd0);

    // Second packet with out_ready low: dropped, overflow set
    send_packet(32'hCAFE_F00D, 32'h0BAD_C0DE, 3'b101, 4'd0, 8);
    repeat (2) @(negedge clk);
    check("ovf_set",  {63'd0, overflow}, 64'd1);
    check("ovf_keep", {b, a}, 64'hDEAD_BEEF_0102_0304);
    check("ovf_op",   {61'd0, op}, 64'd1);
    accept();
    check("ovf_sticky", {63'd0, overflow}, 64'd1);

    // Reset in the middle of the second B byte
    send_frame(1'b0, 8'hFF, 1'b1);
    @(negedge clk) sin = 1'b0;
    @(negedge clk) sin = 1'b0;
    @(negedge clk) sin = 1'b1;
    @(negedge clk) sin = 1'b0;
    @(negedge clk) begin rst_n = 1'b0; sin = 1'b1; end
    @(negedge clk);
    check("mrst_ab",    {b, a}, 64'd0);
    check("mrst_flags", {57'd0, out_valid, op, err_data, err_crc, err_op}, 64'd0);
    check("mrst_ovf",   {62'd0, frame_err, overflow}, 64'd0);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    send_packet(32'h0000_0010, 32'h0000_0020, 3'b000, 4'd0, 8);
    repeat (2) @(negedge clk);
    check("post_valid", {63'd0, out_valid}, 64'd1);
    check("post_ab",    {b, a}, 64'h0000_0010_0000_0020);
    check("post_errs",  {61'd0, err_data, err_crc, err_op}, 64'd0);
    accept();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_sin_decoder.md
ALU_SIN_DECODER -- requirements
Module: alu_sin_decoder

Interface
REQ-001 The block SHALL have no parameters; the frame format and packet length are fixed.
REQ-002 clk  input  1  system clock; all sampling on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 sin  input  1  serial request line, idles high, one bit per clk.
REQ-005 out_ready  input  1  downstream ALU core accepts the current result.
REQ-006 out_valid  output  1  a decoded packet or packet error is presented.
REQ-007 a  output  32  operand A.
REQ-008 b  output  32  operand B.
REQ-009 op  output  3  operation code from the CMD byte.
REQ-010 err_data  output  1  wrong data-frame count before the CMD frame.
REQ-011 err_crc  output  1  CRC mismatch.
REQ-012 err_op  output  1  illegal opcode.
REQ-013 frame_err  output  1  single-cycle pulse: stop bit sampled low.
REQ-014 overflow  output  1  sticky: a packet completed while out_valid was high and was dropped.

Function
REQ-015 Frame format SHALL be 11 bits, one per clk: start 0, type (0 = DATA, 1 = CMD), 8 payload bits MSB first, stop 1.
REQ-016 Frame FSM SHALL use the states IDLE, TYPE, PAYLOAD (3-bit bit counter), STOP.
REQ-017 FSM transitions: IDLE->TYPE on sin==0; TYPE->PAYLOAD; PAYLOAD->STOP after 8 bits; STOP->IDLE.
REQ-018 A new start bit SHALL be accepted on the cycle immediately after a stop bit, giving back-to-back frames with no idle gap.
REQ-019 Packet = 8 DATA frames (B[31:24], B[23:16], B[15:8], B[7:0], then A in the same byte order) followed by 1 CMD frame.
REQ-020 DATA payloads SHALL shift into a 64-bit {B,A} register; the data-frame counter SHALL saturate at 9.
REQ-021 CMD payload layout SHALL be {bit7 ignored, op[2:0], crc[3:0]}.
REQ-022 The expected CRC SHALL be CRC-4 with polynomial x^4+x+1 and initial value 0 over the 68-bit message {B, A, 1'b1, op}, shifted MSB first.
REQ-023 The CRC MAY be computed serially or in parallel; the result SHALL match bit-exactly.
REQ-024 Error priority on CMD: data count != 8 -> err_data only; else CRC mismatch -> err_crc only; else op[1]==1 -> err_op only; else no error.
REQ-025 A CMD frame SHALL always end the packet; the data-frame counter SHALL clear after it.
REQ-026 A stop bit sampled 0 SHALL pulse frame_err for one cycle, discard that frame, clear the data-frame counter, and return the FSM to IDLE.
REQ-027 out_valid, a, b, op and the error flags SHALL update on the clk edge after the CMD stop bit is sampled (1-cycle latency).
REQ-028 Outputs SHALL then hold until the cycle where out_valid && out_ready; out_valid falls on the next edge unless a new packet completes on that same edge.
REQ-029 When a packet completes while out_valid is high and out_ready is low, the new packet SHALL be dropped, the held outputs kept, and overflow set.
REQ-030 When a packet completes on the same edge as an acceptance, the new packet SHALL load and out_valid SHALL stay high; overflow SHALL NOT set.
REQ-031 On error packets, a, b and op SHALL still show the received values; when data count < 8, the unreceived bytes SHALL be 0.
REQ-032 Receiving SHALL continue while out_valid is held.

Reset
REQ-033 Reset SHALL force: FSM IDLE, counters 0, shift and output registers 0, out_valid 0, all flags 0, overflow 0.
REQ-034 Reset asserted mid-frame or mid-packet SHALL discard partial data; the first start bit after release SHALL begin a new packet.
REQ-035 overflow SHALL clear only on reset.

Verification
REQ-036 Valid add: B=0x00000002, A=0x00000003, op=3'b100, correct CRC -> out_valid 1 cycle after CMD stop; a=3, b=2, op=100, all errors 0.
REQ-037 Bad CRC: B=0x12345678, A=0x9ABCDEF0, op=3'b000, CRC+1 -> err_crc=1, err_data=0, err_op=0.
REQ-038 Short packet: 7 DATA frames then CMD -> err_data=1, a[7:0]=0.
REQ-039 Illegal op: op=3'b010 with valid CRC -> err_op=1.
REQ-040 Stop bit 0 on DATA frame 3 -> frame_err pulse; next full packet decodes cleanly; out_ready held 0 across two packets -> overflow=1, first result retained.
REQ-041 rst_n low during B byte 2 -> all outputs 0; following valid packet decodes correctly.
